// File: rtl/pendulum_calib_sequencer.sv
// Pendulum calibration sequencer: synchronizes and debounces the end-stop
// switch, seeks the end-stop, optionally backs off it, locks the servo for a
// settle period while pulsing the encoder zero, and reports DONE or FAULT.
// Optional BACKOFF phase: define PENDULUM_CALIB_BACKOFF_EN to enable it.
module pendulum_calib_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned SEEK_TIMEOUT    = 50_000_000,
  parameter int unsigned SETTLE_CYCLES   = 5_000_000,
  parameter int unsigned BACKOFF_TIMEOUT = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       fault_clr,
  input  logic       sensorFimCurso,
  output logic       calib_start,
  output logic       trava_servo,
  output logic       backoff,
  output logic       pos_zero,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEEK    = 3'd1,
    ST_BACKOFF = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  // Last count value of each timed phase; the counter starts at 0 on entry.
  localparam logic [31:0] DB_LAST      = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] SEEK_LAST    = 32'(SEEK_TIMEOUT - 1);
  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] BACKOFF_LAST = 32'(BACKOFF_TIMEOUT - 1);

  // Where SEEK goes once the end-stop is found.
`ifdef PENDULUM_CALIB_BACKOFF_EN
  localparam state_t SEEK_FOUND = ST_BACKOFF;
`else
  localparam state_t SEEK_FOUND = ST_SETTLE;
`endif

  state_t      cur_state;
  state_t      nxt_state;
  logic        s_meta;
  logic        s_sync;
  logic        sens_db;
  logic [31:0] db_cnt;
  logic [31:0] wait_cnt;
  logic        armed;

  // Two-flop synchronizer for the asynchronous end-stop switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
    end else begin
      s_meta <= sensorFimCurso;
      s_sync <= s_meta;
    end
  end

  // Debouncer: adopt the synced level only after it has differed for a full run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sens_db <= 1'b0;
      db_cnt  <= '0;
    end else if (s_sync == sens_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      sens_db <= s_sync;
      db_cnt  <= '0;
    end else begin
      db_cnt <= db_cnt + 32'd1;
    end
  end

  // Holds the FSM still for the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= ST_IDLE;
    else        cur_state <= nxt_state;
  end

  // Phase counter: clears on every state change, counts inside timed phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      wait_cnt <= '0;
    else if (nxt_state != cur_state) wait_cnt <= '0;
    else if (busy)                   wait_cnt <= wait_cnt + 32'd1;
    else                             wait_cnt <= '0;
  end

  // Next-state logic; abort wins over everything in the busy phases.
  always_comb begin
    nxt_state = cur_state;
    if (armed) begin
      case (cur_state)
        ST_IDLE, ST_DONE: begin
          if (start && !abort) nxt_state = sens_db ? ST_SETTLE : ST_SEEK;
        end
        ST_SEEK: begin
          if (abort)                      nxt_state = ST_IDLE;
          else if (sens_db)               nxt_state = SEEK_FOUND;
          else if (wait_cnt == SEEK_LAST) nxt_state = ST_FAULT;
        end
        ST_BACKOFF: begin
          if (abort)                         nxt_state = ST_IDLE;
          else if (!sens_db)                 nxt_state = ST_SETTLE;
          else if (wait_cnt == BACKOFF_LAST) nxt_state = ST_FAULT;
        end
        ST_SETTLE: begin
          if (abort)                        nxt_state = ST_IDLE;
          else if (wait_cnt == SETTLE_LAST) nxt_state = ST_DONE;
        end
        ST_FAULT: begin
          if (fault_clr) nxt_state = ST_IDLE;
        end
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the current state and phase counter.
  always_comb begin
    state       = cur_state;
    calib_start = (cur_state == ST_SEEK);
`ifdef PENDULUM_CALIB_BACKOFF_EN
    backoff     = (cur_state == ST_BACKOFF);
`else
    backoff     = 1'b0;
`endif
    trava_servo = (cur_state == ST_SETTLE) || (cur_state == ST_FAULT);
    pos_zero    = (cur_state == ST_SETTLE) && (wait_cnt == 32'd0);
    busy        = (cur_state == ST_SEEK) || (cur_state == ST_BACKOFF) ||
                  (cur_state == ST_SETTLE);
    done        = (cur_state == ST_DONE);
    fault       = (cur_state == ST_FAULT);
  end

endmodule

// File: tb/tb_pendulum_calib_sequencer.sv
// Testbench for pendulum_calib_sequencer: a table of directed records, a few
// multi-cycle corner-case sequences and a randomized run, all checked every
// cycle against a behavioural model of the sequencer.
module tb_pendulum_calib_sequencer;

  localparam int DEB      = 4;
  localparam int SEEK_TO  = 100;
  localparam int SETTLE_N = 10;
  localparam int BACK_TO  = 50;

  localparam int S_IDLE    = 0;
  localparam int S_SEEK    = 1;
  localparam int S_BACKOFF = 2;
  localparam int S_SETTLE  = 3;
  localparam int S_DONE    = 4;
  localparam int S_FAULT   = 5;

`ifdef PENDULUM_CALIB_BACKOFF_EN
  localparam bit HAS_BACKOFF = 1'b1;
`else
  localparam bit HAS_BACKOFF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       fault_clr = 1'b0;
  logic       sensorFimCurso = 1'b0;
  logic       calib_start;
  logic       trava_servo;
  logic       backoff;
  logic       pos_zero;
  logic       busy;
  logic       done;
  logic       fault;
  logic [2:0] state;
  logic [9:0] dut_out;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state: phase, cycles spent in it, debounced level,
  // length of the current disagreement run, edges since reset, raw history.
  int m_state;
  int m_time;
  int m_db;
  int m_run;
  int m_edges;
  bit m_raw[$];

  typedef struct {
    logic st;
    logic ab;
    logic fc;
    logic sen;
    int   cycles;
    int   exp_state;
  } vec_t;

  vec_t tbl[15];

  pendulum_calib_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .SEEK_TIMEOUT(SEEK_TO),
    .SETTLE_CYCLES(SETTLE_N),
    .BACKOFF_TIMEOUT(BACK_TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .fault_clr(fault_clr),
    .sensorFimCurso(sensorFimCurso),
    .calib_start(calib_start),
    .trava_servo(trava_servo),
    .backoff(backoff),
    .pos_zero(pos_zero),
    .busy(busy),
    .done(done),
    .fault(fault),
    .state(state)
  );

  assign dut_out = {calib_start, trava_servo, backoff, pos_zero, busy, done, fault, state};

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    m_state = S_IDLE;
    m_time  = 0;
    m_db    = 0;
    m_run   = 0;
    m_edges = 0;
    m_raw.delete();
  endtask

  // One rising edge of the intended behaviour.
  task automatic modelStep(input logic st, input logic ab, input logic fc, input logic sen);
    int synced;
    int nxt;
    if (!rst_n) return;
    synced = (m_raw.size() == 2) ? int'(m_raw[0]) : 0;
    m_raw.push_back(sen);
    if (m_raw.size() > 2) void'(m_raw.pop_front());
    nxt = m_state;
    if (m_edges > 0) begin
      case (m_state)
        S_IDLE, S_DONE: if (st && !ab) nxt = (m_db != 0) ? S_SETTLE : S_SEEK;
        S_SEEK: begin
          if (ab) nxt = S_IDLE;
          else if (m_db != 0) nxt = HAS_BACKOFF ? S_BACKOFF : S_SETTLE;
          else if (m_time + 1 == SEEK_TO) nxt = S_FAULT;
        end
        S_BACKOFF: begin
          if (ab) nxt = S_IDLE;
          else if (m_db == 0) nxt = S_SETTLE;
          else if (m_time + 1 == BACK_TO) nxt = S_FAULT;
        end
        S_SETTLE: begin
          if (ab) nxt = S_IDLE;
          else if (m_time + 1 == SETTLE_N) nxt = S_DONE;
        end
        S_FAULT: if (fc) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
    m_time  = (nxt != m_state) ? 0 : m_time + 1;
    m_state = nxt;
    if (synced != m_db) begin
      m_run++;
      if (m_run == DEB) begin
        m_db  = synced;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_edges++;
  endtask

  function automatic logic [9:0] modelOut();
    logic [9:0] v;
    v      = '0;
    v[9]   = (m_state == S_SEEK);
    v[8]   = (m_state == S_SETTLE) || (m_state == S_FAULT);
    v[7]   = (m_state == S_BACKOFF);
    v[6]   = (m_state == S_SETTLE) && (m_time == 0);
    v[5]   = (m_state == S_SEEK) || (m_state == S_BACKOFF) || (m_state == S_SETTLE);
    v[4]   = (m_state == S_DONE);
    v[3]   = (m_state == S_FAULT);
    v[2:0] = 3'(m_state);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [9:0] expected);
    vectors++;
    if (dut_out !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: outputs got %b expected %b (t=%0t)", name, dut_out, expected, $time);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int expected);
    vectors++;
    if (got != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, got, expected, $time);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, compare.
  task automatic applyStimulus(input logic st, input logic ab, input logic fc, input logic sen);
    start          = st;
    abort          = ab;
    fault_clr      = fc;
    sensorFimCurso = sen;
    @(posedge clk);
    modelStep(st, ab, fc, sen);
    @(negedge clk);
    checkOutput("model", modelOut());
  endtask

  // Asserts reset mid-cycle and checks the outputs clear before any edge.
  task automatic doReset();
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_async", 10'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic sen_lvl;
    int   enter_i;
    int   done_i;
    int   pz;
    int   bo;
    int   bo_i;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3,  S_IDLE};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  S_SEEK};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5,  S_SEEK};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 94, S_SEEK};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  S_FAULT};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3,  S_FAULT};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1,  S_IDLE};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8,  S_IDLE};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  S_SETTLE};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9,  S_SETTLE};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  S_DONE};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8,  S_DONE};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  S_SEEK};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  S_IDLE};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 2,  S_IDLE};

    $display("[TB] table-driven records");
    doReset();
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < tbl[r].cycles; c++)
        applyStimulus(tbl[r].st, tbl[r].ab, tbl[r].fc, tbl[r].sen);
      checkValue($sformatf("table_row%0d_state", r), int'(state), tbl[r].exp_state);
    end

    $display("[TB] first transition holdoff after reset");
    start = 1'b1;
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("holdoff_first_edge", int'(state), S_IDLE);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("holdoff_second_edge", int'(state), S_SEEK);

`ifndef PENDULUM_CALIB_BACKOFF_EN
    $display("[TB] homing with sensor rising at cycle 20");
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    enter_i = -1;
    done_i  = -1;
    pz      = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(i == 0, 1'b0, 1'b0, i >= 20);
      if (pos_zero) pz++;
      if (state == 3'd3 && enter_i < 0) enter_i = i;
      if (done && done_i < 0) done_i = i;
    end
    checkValue("settle_by_cycle27", int'(enter_i >= 0 && enter_i <= 27), 1);
    checkValue("pos_zero_pulses", pz, 1);
    checkValue("done_after_settle", done_i - enter_i, SETTLE_N);
`else
    $display("[TB] homing with backoff, sensor released 15 cycles after rising");
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    enter_i = -1;
    bo_i    = -1;
    bo      = 0;
    pz      = 0;
    for (int i = 0; i < 80; i++) begin
      applyStimulus(i == 0, 1'b0, 1'b0, (i >= 20) && (i < 35));
      if (backoff) bo++;
      if (pos_zero) pz++;
      if (state == 3'd2 && bo_i < 0) bo_i = i;
      if (state == 3'd3 && enter_i < 0) enter_i = i;
    end
    checkValue("backoff_entered", int'(bo_i >= 0), 1);
    checkValue("backoff_cycles", bo, 15);
    checkValue("settle_after_backoff", enter_i - bo_i, 15);
    checkValue("pos_zero_pulses", pz, 1);
`endif

    $display("[TB] short sensor glitches during seek");
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 60; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, (i % 4) != 0);
    checkValue("glitch_still_seek", int'(state), S_SEEK);
    for (int i = 0; i < 40; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("seek_timeout_state", int'(state), S_FAULT);
    checkValue("fault_and_lock", int'({fault, trava_servo}), 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkValue("fault_clr_to_idle", int'(state), S_IDLE);

    $display("[TB] abort in the fifth settle cycle");
    doReset();
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkValue("settle_direct", int'(state), S_SETTLE);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkValue("abort_settle_state", int'(state), S_IDLE);
    checkValue("abort_settle_lock", int'(trava_servo), 0);

    $display("[TB] reset asserted mid-seek");
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("pre_reset_seek", int'(state), S_SEEK);
    doReset();

    $display("[TB] randomized run against the model");
    sen_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int flip_div;
      flip_div = (i < 1500) ? 12 : 150;
      if ($urandom_range(flip_div - 1, 0) == 0) sen_lvl = ~sen_lvl;
      if ($urandom_range(499, 0) == 0) doReset();
      applyStimulus($urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0,
                    $urandom_range(7, 0) == 0, sen_lvl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pendulum_calib_sequencer.md
PENDULUM_CALIB_SEQUENCER -- requirements
Module: pendulum_calib_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000, meaning the stable cycles required on the synced end-stop before the debounced level changes.
REQ-002 SHALL have parameter SEEK_TIMEOUT, default 50_000_000, meaning the maximum cycles spent in SEEK before FAULT.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 5_000_000, meaning the cycles the servo stays locked after homing.
REQ-004 SHALL have parameter BACKOFF_TIMEOUT, default 10_000_000, meaning the maximum cycles spent in BACKOFF before FAULT (used only with the macro).
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  system clock; rst_n  in  1  async active-low reset.
REQ-006 start  in  1  calibration request, level-sampled.
REQ-007 abort  in  1  cancel calibration.
REQ-008 fault_clr  in  1  clear FAULT.
REQ-009 sensorFimCurso  in  1  raw end-stop switch, asynchronous.
REQ-010 calib_start  out  1  drives the input mux toward the end-stop.
REQ-011 trava_servo  out  1  servo lock to the input mux.
REQ-012 backoff  out  1  request to drive away from the end-stop.
REQ-013 pos_zero  out  1  one-cycle encoder-zero pulse.
REQ-014 busy  out  1  high in SEEK, BACKOFF and SETTLE.
REQ-015 done  out  1  high in DONE.
REQ-016 fault  out  1  high in FAULT.
REQ-017 state  out  3  state code: IDLE=0, SEEK=1, BACKOFF=2, SETTLE=3, DONE=4, FAULT=5.

Function
REQ-018 sensorFimCurso SHALL pass through a 2-FF synchronizer, giving s_sync.
REQ-019 sens_db SHALL take the value of s_sync after s_sync differs from sens_db for DEBOUNCE_CYCLES consecutive cycles; any glitch SHALL restart the count.
REQ-020 Moore outputs: calib_start=1 only in SEEK; backoff=1 only in BACKOFF; trava_servo=1 in SETTLE and FAULT.
REQ-021 IDLE or DONE with start=1 and abort=0: next state SHALL be SETTLE if sens_db=1, else SEEK; the wait counter SHALL clear.
REQ-022 SEEK with sens_db=1: next state SHALL be BACKOFF with the macro, else SETTLE.
REQ-023 SEEK, while sens_db=0: the counter SHALL increment each cycle; on reaching SEEK_TIMEOUT the next state SHALL be FAULT.
REQ-024 BACKOFF with sens_db=0: next state SHALL be SETTLE.
REQ-025 BACKOFF reaching BACKOFF_TIMEOUT: next state SHALL be FAULT.
REQ-026 pos_zero SHALL pulse for exactly the first cycle of SETTLE.
REQ-027 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to DONE.
REQ-028 abort=1 in SEEK, BACKOFF or SETTLE SHALL give IDLE next cycle; abort SHALL override start when both are high.
REQ-029 start SHALL be ignored while busy=1 or in FAULT.
REQ-030 FAULT SHALL be left only via fault_clr=1, to IDLE; start SHALL be ignored in the clearing cycle.
REQ-031 If sens_db falls during SETTLE, the block SHALL still complete the SETTLE timing (no re-seek).
REQ-032 The counter SHALL be 32 bits and SHALL clear on every state change.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, all outputs 0, counters 0, sens_db=0 and synchronizer stages 0, including mid-SEEK or mid-SETTLE.
REQ-034 The first state transition after reset release SHALL occur no earlier than the second rising clock edge.

Configuration
REQ-035 With macro PENDULUM_CALIB_BACKOFF_EN defined, the block SHALL include BACKOFF as in REQ-022, REQ-024 and REQ-025.
REQ-036 Without PENDULUM_CALIB_BACKOFF_EN, BACKOFF SHALL be unreachable, backoff SHALL be tied 0 and SEEK SHALL go directly to SETTLE.

Verification (DEBOUNCE_CYCLES=4, SEEK_TIMEOUT=100, SETTLE_CYCLES=10, BACKOFF_TIMEOUT=50)
REQ-037 Start pulse, sensor rises at cycle 20 and stays high, no macro -> SETTLE entered by cycle 27; pos_zero high for one cycle; done=1 exactly 10 cycles later.
REQ-038 Start pulse, sensor never rises -> FAULT after 100 SEEK cycles with fault=1 and trava_servo=1; fault_clr -> IDLE.
REQ-039 Sensor 2-cycle glitches during SEEK -> sens_db stays 0 and the block stays in SEEK.
REQ-040 With the macro: sensor high then released 15 cycles later -> BACKOFF with backoff=1, then SETTLE once sens_db=0.
REQ-041 abort and start high together in IDLE -> stays IDLE; abort at cycle 5 of SETTLE -> IDLE next cycle, trava_servo=0.
REQ-042 rst_n pulsed low mid-SEEK -> all outputs 0 without waiting for a clock edge; state=0.
